// File: rtl/ysyx_22040759_rd_sched.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040759_rd_sched
// Brief   : Arbitrates icache fetches and mem loads onto one read engine,
//           with a write-hazard block for loads and starvation relief for fetches.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040759_rd_sched #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      icache_addr_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] icache_rd_addr_i,
  output logic                      icache_data_valid_o,
  output logic [63:0]               icache_data_o,
  input  logic                      mem_rd_addr_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] mem_rd_addr_i,
  input  logic [2:0]                mem_rd_size_i,
  output logic                      mem_rd_data_valid_o,
  output logic [63:0]               mem_rd_data_o,
  input  logic                      wr_pending_i,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_pending_addr_i,
  output logic                      rd_addr_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [2:0]                rd_size_o,
  input  logic                      rd_data_valid_i,
  input  logic [63:0]               rd_data_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_M = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [2:0] C_ICACHE_SIZE  = 3'b011;
  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [3:0]                  r_starve_cnt;
  logic                        r_rd_addr_valid;
  logic [AXI_ADDR_WIDTH-1:0]   r_rd_addr;
  logic [2:0]                  r_rd_size;
  logic                        r_icache_data_valid;
  logic [63:0]                 r_icache_data;
  logic                        r_mem_data_valid;
  logic [63:0]                 r_mem_data;

  logic w_mem_hazard;
  logic w_mem_elig;
  logic w_ic_elig;
  logic w_grant_i;
  logic w_grant_m;
  logic w_rd_done;
  logic w_unused;

  // Loads may not overtake a pending write to the same 8-byte beat.
  assign w_mem_hazard = wr_pending_i &&
                        (wr_pending_addr_i[AXI_ADDR_WIDTH-1:3] == mem_rd_addr_i[AXI_ADDR_WIDTH-1:3]);
  assign w_mem_elig   = mem_rd_addr_valid_i && !w_mem_hazard;
  assign w_ic_elig    = icache_addr_valid_i;
  assign w_unused     = ^wr_pending_addr_i[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_m   = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ic_elig && (r_starve_cnt >= C_STARVE_LIMIT)) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_BUSY_I;
        end else if (w_mem_elig) begin
          w_grant_m   = 1'b1;
          w_state_nxt = S_BUSY_M;
        end else if (w_ic_elig) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_M: begin
        if (rd_data_valid_i) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt        <= 4'd0;
      r_rd_addr_valid     <= 1'b0;
      r_rd_addr           <= '0;
      r_rd_size           <= 3'd0;
      r_icache_data_valid <= 1'b0;
      r_icache_data       <= 64'd0;
      r_mem_data_valid    <= 1'b0;
      r_mem_data          <= 64'd0;
    end else begin
      r_icache_data_valid <= 1'b0;
      r_mem_data_valid    <= 1'b0;

      if (w_grant_i) begin
        r_rd_addr_valid <= 1'b1;
        r_rd_addr       <= icache_rd_addr_i;
        r_rd_size       <= C_ICACHE_SIZE;
        r_starve_cnt    <= 4'd0;
      end else if (w_grant_m) begin
        r_rd_addr_valid <= 1'b1;
        r_rd_addr       <= mem_rd_addr_i;
        r_rd_size       <= mem_rd_size_i;
        // Only loads that overtake a waiting fetch count toward starvation.
        if (!icache_addr_valid_i) begin
          r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt < C_STARVE_LIMIT) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end

      if (w_rd_done) begin
        r_rd_addr_valid <= 1'b0;
        if (r_state == S_BUSY_I) begin
          r_icache_data_valid <= 1'b1;
          r_icache_data       <= rd_data_i;
        end else begin
          r_mem_data_valid <= 1'b1;
          r_mem_data       <= rd_data_i;
        end
      end
    end
  end

  assign rd_addr_valid_o     = r_rd_addr_valid;
  assign rd_addr_o           = r_rd_addr;
  assign rd_size_o           = r_rd_size;
  assign icache_data_valid_o = r_icache_data_valid;
  assign icache_data_o       = r_icache_data;
  assign mem_rd_data_valid_o = r_mem_data_valid;
  assign mem_rd_data_o       = r_mem_data;

endmodule
`default_nettype wire
